// File: rtl/everloop_rx.sv
// everloop_rx: decodes the pulse-width serial LED stream into RAM byte writes.
// A high pulse of at least T_BIT_THRESH cycles is a 1, shorter is a 0; bytes
// arrive MSB first, and a low run of T_RESET cycles closes the frame.
module everloop_rx #(
    parameter int ADR_WIDTH    = 11,
    parameter int DAT_WIDTH    = 8,
    parameter int T_BIT_THRESH = 30,
    parameter int T_MAX_HIGH   = 100,
    parameter int T_RESET      = 2500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [ADR_WIDTH-1:0] adr,
    output logic [DAT_WIDTH-1:0] dat,
    output logic                 we,
    output logic                 frame_done,
    output logic [ADR_WIDTH:0]   byte_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [15:0]        THRESH_C   = 16'(T_BIT_THRESH);
    localparam logic [15:0]        MAX_HIGH_C = 16'(T_MAX_HIGH);
    localparam logic [15:0]        T_RESET_C  = 16'(T_RESET);
    localparam logic [3:0]         LAST_BIT_C = 4'(DAT_WIDTH - 1);
    // Pointer value meaning "RAM already full"; the pointer never goes past it.
    localparam logic [ADR_WIDTH:0] PTR_FULL_C = {1'b1, {ADR_WIDTH{1'b0}}};
    localparam logic [ADR_WIDTH:0] PTR_ONE_C  = {{ADR_WIDTH{1'b0}}, 1'b1};

    // Pulse counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t                 state_r, state_nx;
    logic                   din_meta_r, din_s_r;
    logic [15:0]            cnt_r, cnt_nx;
    logic [ADR_WIDTH:0]     ptr_r, ptr_nx;
    logic [3:0]             bits_r, bits_nx;
    logic [DAT_WIDTH-1:0]   sh_r, sh_nx;
    logic [DAT_WIDTH-1:0]   byte_s;
    logic                   bit_s;
    logic                   we_nx, fd_nx, err_nx;
    logic [ADR_WIDTH-1:0]   adr_nx;
    logic [DAT_WIDTH-1:0]   dat_nx;
    logic [ADR_WIDTH:0]     bc_nx;

    // Bit value of the pulse that just ended, and the byte it completes.
    assign bit_s  = (cnt_r >= THRESH_C);
    assign byte_s = {sh_r[DAT_WIDTH-2:0], bit_s};

    // Two-flop synchronizer for the asynchronous data line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_meta_r <= 1'b0;
            din_s_r    <= 1'b0;
        end else begin
            din_meta_r <= din;
            din_s_r    <= din_meta_r;
        end
    end

    // Next-state and next-output decode; edges are implied by the state
    // (a high sample in IDLE/LOW is a rising edge, a low sample in HIGH a falling edge).
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        ptr_nx   = ptr_r;
        bits_nx  = bits_r;
        sh_nx    = sh_r;
        we_nx    = 1'b0;
        fd_nx    = 1'b0;
        adr_nx   = adr;
        dat_nx   = dat;
        bc_nx    = byte_cnt;
        err_nx   = err;
        case (state_r)
            SYNC: begin
                ptr_nx  = '0;
                bits_nx = 4'd0;
                if (din_s_r) begin
                    cnt_nx = 16'd0;
                end else if (cnt_r >= T_RESET_C) begin
                    cnt_nx   = 16'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = sat_inc(cnt_r);
                end
            end
            IDLE: begin
                ptr_nx  = '0;
                bits_nx = 4'd0;
                if (din_s_r) begin
                    err_nx   = 1'b0;
                    cnt_nx   = 16'd1;
                    state_nx = HIGH;
                end else begin
                    cnt_nx = 16'd0;
                end
            end
            HIGH: begin
                if (cnt_r >= MAX_HIGH_C) begin
                    // Line stuck high: abandon the frame and resynchronise.
                    err_nx   = 1'b1;
                    bits_nx  = 4'd0;
                    cnt_nx   = 16'd0;
                    state_nx = SYNC;
                end else if (!din_s_r) begin
                    sh_nx    = byte_s;
                    cnt_nx   = 16'd1;
                    state_nx = LOW;
                    if (bits_r == LAST_BIT_C) begin
                        bits_nx = 4'd0;
                        if (ptr_r == PTR_FULL_C) begin
                            err_nx = 1'b1;
                        end else begin
                            we_nx  = 1'b1;
                            adr_nx = ptr_r[ADR_WIDTH-1:0];
                            dat_nx = byte_s;
                            ptr_nx = ptr_r + PTR_ONE_C;
                        end
                    end else begin
                        bits_nx = bits_r + 4'd1;
                    end
                end else begin
                    cnt_nx = sat_inc(cnt_r);
                end
            end
            LOW: begin
                if (din_s_r) begin
                    // A rising edge wins over a simultaneous gap timeout.
                    cnt_nx   = 16'd1;
                    state_nx = HIGH;
                end else if (cnt_r >= T_RESET_C) begin
                    fd_nx    = (ptr_r != '0);
                    bc_nx    = ptr_r;
                    err_nx   = err | (bits_r != 4'd0);
                    bits_nx  = 4'd0;
                    ptr_nx   = '0;
                    cnt_nx   = 16'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = sat_inc(cnt_r);
                end
            end
            default: begin
                cnt_nx   = 16'd0;
                state_nx = SYNC;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= SYNC;
            cnt_r      <= 16'd0;
            ptr_r      <= '0;
            bits_r     <= 4'd0;
            sh_r       <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            adr        <= '0;
            dat        <= '0;
            byte_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            ptr_r      <= ptr_nx;
            bits_r     <= bits_nx;
            sh_r       <= sh_nx;
            we         <= we_nx;
            frame_done <= fd_nx;
            adr        <= adr_nx;
            dat        <= dat_nx;
            byte_cnt   <= bc_nx;
            err        <= err_nx;
        end
    end

endmodule

// File: doc/everloop_rx.md
EVERLOOP_RX -- requirements
Module: everloop_rx

Interface
REQ-001 SHALL provide parameter ADR_WIDTH, default 11, the width of the write address.
REQ-002 SHALL provide parameter DAT_WIDTH, default 8, the byte width (fixed at 8 for decoding).
REQ-003 SHALL provide parameter T_BIT_THRESH, default 30, the high-pulse cycle count at or above which a bit decodes as 1.
REQ-004 SHALL provide parameter T_MAX_HIGH, default 100, the high-pulse cycle count treated as a line fault.
REQ-005 SHALL provide parameter T_RESET, default 2500, the low-run cycle count that marks a latch/reset gap.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL provide port din, input, 1 bit: the asynchronous serial LED-data line (everloop_d format).
REQ-009 SHALL provide port adr, output, ADR_WIDTH bits: the RAM write address.
REQ-010 SHALL provide port dat, output, 8 bits: the RAM write data.
REQ-011 SHALL provide port we, output, 1 bit: the RAM write strobe, one cycle per byte.
REQ-012 SHALL provide port frame_done, output, 1 bit: a one-cycle pulse at the end of each frame.
REQ-013 SHALL provide port byte_cnt, output, ADR_WIDTH+1 bits: bytes written in the last completed frame.
REQ-014 SHALL provide port err, output, 1 bit: sticky fault flag, cleared at the start of the next frame.

Function
REQ-015 SHALL pass din through a 2-flop synchronizer (din_s); all edges and counts are taken on din_s.
REQ-016 SHALL use a 16-bit pulse counter that saturates at all-ones and never wraps.
REQ-017 SHALL implement the states SYNC, IDLE, HIGH and LOW.
REQ-018 SYNC: count consecutive low cycles, clearing on any high; when the count reaches T_RESET, go to IDLE. This state is entered after reset.
REQ-019 IDLE: hold pointer=0 and bit count=0; on a din_s rising edge, clear err, load counter=1 and go to HIGH.
REQ-020 HIGH: increment the counter while din_s=1.
REQ-021 HIGH, on a falling edge: decode bit = (counter >= T_BIT_THRESH), shift it into the byte MSB-first, load counter=1 and go to LOW.
REQ-022 HIGH, if the counter reaches T_MAX_HIGH: set err, discard the partial byte and go to SYNC.
REQ-023 LOW: increment the counter while din_s=0; on a rising edge, load counter=1 and go to HIGH.
REQ-024 LOW, if the counter reaches T_RESET: go to IDLE and pulse frame_done for one cycle.
REQ-025 LOW, at that frame end, byte_cnt SHALL take the pointer value.
REQ-026 LOW, at that frame end, a nonzero partial bit count SHALL set err and discard the partial byte.
REQ-027 On the 8th bit: the cycle after the falling edge is seen on din_s, the block SHALL drive we=1, adr=pointer and dat=assembled byte; the pointer then increments and the bit count clears.
REQ-028 Latency SHALL be we asserted 3 clk after the din falling edge of the 8th bit (2 synchronizer + 1 register).
REQ-029 adr and dat SHALL be registered and hold their last values while we=0.
REQ-030 Pointer full: bytes arriving when the pointer = 2^ADR_WIDTH SHALL NOT be written; such a byte sets err, and the pointer does not wrap.
REQ-031 A frame with zero bytes (a glitch-free gap only) SHALL produce no frame_done pulse.
REQ-032 If a rising edge and counter saturation coincide, the edge SHALL take priority.

Reset
REQ-033 With rst=0 at a clock edge, the block SHALL enter SYNC with counter, pointer and bit count = 0.
REQ-034 During reset, adr=0, dat=0, we=0, frame_done=0, byte_cnt=0 and err=0.
REQ-035 Reset asserted mid-byte or mid-frame SHALL abort it with no write, and no frame_done follows.
REQ-036 After reset release, no byte SHALL be accepted until T_RESET low cycles have been observed.

Verification
REQ-037 After reset and 2500 low cycles, send 0xA5 as high widths 40/20/40/20/20/40/20/40 with 60-cycle bit periods, then 2500 low -> exactly one we with adr=0, dat=0xA5, then frame_done=1 with byte_cnt=1 and err=0.
REQ-038 Send 3 bytes 0x00, 0xFF, 0x3C, then a gap, then 1 byte 0x81 -> writes at adr 0,1,2 then adr 0; byte_cnt=3 then 1.
REQ-039 Threshold boundary: high widths of 29 and 30 cycles -> decoded as 0 and 1 respectively.
REQ-040 A high pulse of 100 cycles mid-byte -> err=1, no we, SYNC entered; the next valid frame clears err and writes at adr 0.
REQ-041 Send 12 bits then a gap -> one write (first 8 bits), frame_done with byte_cnt=1 and err=1.
REQ-042 With ADR_WIDTH=2, send 5 bytes -> writes at adr 0..3 only, 5th dropped, err=1, byte_cnt=4.
REQ-043 Assert rst during the 5th bit of a byte -> no we; after release, data sent before 2500 low cycles is ignored.
